// File: rtl/imem_refill_ctrl.sv
// imem_refill_ctrl: I-cache refill controller, four word-serial read beats per 128-bit line.
// Optional macro IMEM_CRITICAL_WORD_FIRST_EN: fetch the missed word first and wrap around the line.
module imem_refill_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                miss_req,
    input  logic [ADDR_W-1:0]   miss_addr,
    input  logic                flush,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [4*DATA_W-1:0] line_out,
    output logic [ADDR_W-1:0]   fill_addr,
    output logic                fill_valid,
    output logic                stall
);
    localparam int unsigned LINE_W = ADDR_W - 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] FILL = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [1:0]        cnt;
    logic [1:0]        word;
    logic [LINE_W-1:0] line_idx;
    logic              load;
    logic              beat;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and beat/load control; flush always wins
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        beat      = 1'b0;
        case (state)
            IDLE: begin
                if (miss_req && !flush) begin
                    state_nxt = REQ;
                    load      = 1'b1;
                end
            end
            REQ: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (mem_ready) begin
                    beat = 1'b1;
                    if (cnt == 2'd3) begin
                        state_nxt = FILL;
                    end
                end
            end
            FILL: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Line index latch, beat counter and line assembly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_idx <= '0;
            cnt      <= 2'd0;
            line_out <= '0;
        end else begin
            if (load) begin
                line_idx <= miss_addr[ADDR_W-1:4];
                cnt      <= 2'd0;
            end else if (beat) begin
                cnt <= cnt + 2'd1;
                for (int k = 0; k < 4; k++) begin
                    if (word == 2'(k)) begin
                        line_out[k*DATA_W +: DATA_W] <= mem_rdata;
                    end
                end
            end
        end
    end

`ifdef IMEM_CRITICAL_WORD_FIRST_EN
    logic [1:0] start_off;
    logic       unused_bits;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_off <= 2'd0;
        end else if (load) begin
            start_off <= miss_addr[3:2];
        end
    end

    // Modulo-4 wrap starting at the missed word
    assign word        = start_off + cnt;
    assign unused_bits = ^miss_addr[1:0];
`else
    logic unused_bits;

    assign word        = cnt;
    assign unused_bits = ^miss_addr[3:0];
`endif

    assign mem_req    = (state == REQ);
    assign mem_addr   = {line_idx, word, 2'b00};
    assign fill_addr  = {line_idx, 4'b0000};
    assign fill_valid = (state == FILL) && !flush;
    assign stall      = (state != IDLE) || (miss_req && !flush);

endmodule

// File: doc/imem_refill_ctrl.md
# imem_refill_ctrl

Instruction-cache refill controller sitting directly upstream of `fetch_instruction_memory`. On a fetch miss it issues four word-serial read beats to main memory. It packs the returned words into the 128-bit line that drives the cache's `mem_in`, then pulses a one-cycle fill strobe. While a refill is in flight it stalls the PC stage.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: word / beat width; line is `4*DATA_W`.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `miss_req`  in  1  cache miss for `miss_addr`; level, held by the cache until `fill_valid`.
- `miss_addr`  in  ADDR_W  byte address of the missing instruction.
- `flush`  in  1  abort any refill (branch redirect); no fill produced.
- `mem_req`  out  1  read beat request to memory.
- `mem_addr`  out  ADDR_W  word-aligned byte address of the current beat.
- `mem_ready`  in  1  memory returns `mem_rdata` this cycle; only meaningful while `mem_req`=1.
- `mem_rdata`  in  DATA_W  returned word.
- `line_out`  out  4*DATA_W  assembled line to cache `mem_in`; word k at bits [32k+31:32k].
- `fill_addr`  out  ADDR_W  line-aligned address of `line_out` (bits [3:0]=0).
- `fill_valid`  out  1  one-cycle pulse: `line_out`/`fill_addr` valid, cache writes line.
- `stall`  out  1  freeze PC/fetch.

## Operation
- Line index = `miss_addr[ADDR_W-1:4]`; word offset = `miss_addr[3:2]`; `miss_addr[1:0]` ignored.
- States: IDLE, REQ, FILL.
  - IDLE: `miss_req`=1 and `flush`=0 → latch line index and start offset, beat counter `cnt`=0, go REQ.
  - REQ: `mem_req`=1; `mem_addr` = {line, word(cnt), 2'b00}. On `mem_ready`, write `mem_rdata` into word slot word(cnt) and increment `cnt`. On the beat with `cnt`=3 → FILL.
  - FILL: `fill_valid`=1 for exactly this cycle → IDLE.
- word(cnt) is 2-bit modular arithmetic; see Configuration.
- `flush`=1 in any state → IDLE next cycle, with no `fill_valid` and no further `mem_req`. Flush wins over a simultaneous final beat or FILL entry. In FILL, flush suppresses `fill_valid` (combinational gate).
- `miss_req` arriving in REQ/FILL is ignored. The cache re-presents it after the fill and then hits, or misses again from IDLE.
- `stall` = (state≠IDLE) | (state==IDLE & `miss_req` & ~`flush`), combinational.
- `line_out` holds its last contents between refills and is overwritten beat by beat; only contents at `fill_valid` are defined.

## Timing
- Reset values: state=IDLE, `cnt`=0, `mem_req`=0, `mem_addr`=0, `line_out`=0, `fill_addr`=0, `fill_valid`=0. Derived: `stall`=0 when `miss_req`=0.
- Reset mid-refill: immediate return to IDLE, outputs at reset values, partial line discarded.
- Miss seen in IDLE at cycle 0 → `mem_req` high from cycle 1.
- With `mem_ready` tied high: beats in cycles 1–4, `fill_valid` in cycle 5, IDLE in cycle 6. Minimum miss penalty is 6 cycles.
- Each `mem_ready`=0 cycle in REQ adds one cycle. `mem_addr` stays stable until the beat is accepted.
- `fill_valid` never occurs on consecutive cycles; minimum gap is 5 cycles.

## Configuration
- `IMEM_CRITICAL_WORD_FIRST_EN` defined:
  - word(cnt) = start offset + cnt (mod 4), so the requested word is fetched first and the sequence wraps around (e.g. 2,3,0,1).
  - `line_out` is identical to the in-order case: each word lands in its own slot.
- Not defined: word(cnt) = cnt (order 0,1,2,3); the start offset is ignored for ordering.

## Test plan
- Reset with `rst`=0 mid-REQ → all outputs at reset values within the same cycle. After release with `miss_req`=0, `mem_req` stays 0.
- Miss at 0x0000_0008, `mem_ready`=1, memory returns 0x0000_7C00, 0xFFFF_FFFF, 0x0000_0000, 0xFFFF_FFFF for words 0–3:
  - `fill_valid` fires at cycle 5 with `fill_addr`=0x0000_0000.
  - `line_out` = 0xFFFFFFFF_00000000_FFFFFFFF_00007C00.
  - `stall`=1 for cycles 0–5.
- Same miss with the macro defined → `mem_addr` sequence 0x8, 0xC, 0x0, 0x4. Without the macro → 0x0, 0x4, 0x8, 0xC. Identical `line_out` in both builds.
- `mem_ready` low for 2 cycles before beat 2 → `mem_addr` held at the beat-2 address and `fill_valid` delayed to cycle 7.
- `flush` asserted on the cycle of the final beat → no `fill_valid`, IDLE next cycle, `stall`=0 if `miss_req`=0.
- `miss_req` toggled with a new address during REQ → no change to `mem_addr` line bits; `fill_addr` equals the original line.
